// File: rtl/id_stage_hs.sv
// id_stage_hs: registered RV32I decode stage with valid/ready handshakes.
//
// Captures an instruction from the IF/ID register and presents it to EX one
// cycle later as a registered bundle. The bundle holds the control word, the
// raw instruction, the PC, both source operands, the selected immediate and
// the register indices. The regfile lives here. When BYPASS is set, a
// same-cycle WB write is visible to the capture. A held bundle's operands
// track WB writes so that they stay coherent while EX back-pressures.
//
// Ports
//   clk, rst                        clock (rising edge), async active-low reset
//   in_valid_i / in_ready_o         upstream handshake
//   instr_i, pc_i                   instruction word and its PC
//   wb_load_i, wb_rd_i, wb_data_i   regfile write port from WB
//   flush_i                         kill the held instruction and any input taken now
//   hd_zero_i                       strip side effects from the instruction being captured
//   out_valid_o / out_ready_i       downstream handshake
//   ctrl_word_o ... rd_o            registered decode bundle
//   br_en_o                         comparator on the registered operands
//   lu_stall_o                      load-use stall this cycle

package id_stage_hs_pkg;

   localparam logic [6:0] OP_LUI   = 7'b0110111;
   localparam logic [6:0] OP_AUIPC = 7'b0010111;
   localparam logic [6:0] OP_JAL   = 7'b1101111;
   localparam logic [6:0] OP_JALR  = 7'b1100111;
   localparam logic [6:0] OP_BR    = 7'b1100011;
   localparam logic [6:0] OP_LOAD  = 7'b0000011;
   localparam logic [6:0] OP_STORE = 7'b0100011;
   localparam logic [6:0] OP_IMM   = 7'b0010011;
   localparam logic [6:0] OP_REG   = 7'b0110011;

   // cmpop uses the branch funct3 encoding
   localparam logic [2:0] CMP_BEQ  = 3'b000;
   localparam logic [2:0] CMP_BLT  = 3'b100;
   localparam logic [2:0] CMP_BLTU = 3'b110;

   localparam logic [1:0] RF_ALU = 2'd0;
   localparam logic [1:0] RF_IMM = 2'd1;
   localparam logic [1:0] RF_MEM = 2'd2;
   localparam logic [1:0] RF_PC4 = 2'd3;

   typedef struct packed {
      logic [6:0] opcode;
      logic [2:0] aluop;
      logic       alu_alt;        // sub / sra
      logic       alumux1_sel;    // 0: rs1, 1: pc
      logic       alumux2_sel;    // 0: rs2, 1: imm
      logic [2:0] cmpop;
      logic       cmpmux_sel;     // 0: rs2, 1: imm
      logic [1:0] regfilemux_sel;
      logic       load_regfile;
      logic       mem_read;
      logic       mem_write;
      logic [3:0] mem_byte_en;
   } rv32i_control_word;

endpackage

module id_stage_hs
   import id_stage_hs_pkg::*;
#(
   parameter int XLEN     = 32,
   parameter int NUM_REGS = 32,
   parameter bit BYPASS   = 1'b1,
   parameter bit LU_CHECK = 1'b1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [31:0]       instr_i,
   input  logic [XLEN-1:0]   pc_i,
   input  logic              wb_load_i,
   input  logic [4:0]        wb_rd_i,
   input  logic [XLEN-1:0]   wb_data_i,
   input  logic              flush_i,
   input  logic              hd_zero_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output rv32i_control_word ctrl_word_o,
   output logic [31:0]       instr_o,
   output logic [XLEN-1:0]   pc_o,
   output logic [XLEN-1:0]   rs1_data_o,
   output logic [XLEN-1:0]   rs2_data_o,
   output logic [XLEN-1:0]   imm_o,
   output logic [4:0]        rs1_o,
   output logic [4:0]        rs2_o,
   output logic [4:0]        rd_o,
   output logic              br_en_o,
   output logic              lu_stall_o
);

   localparam int AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

   function automatic logic [3:0] byte_en(input logic [1:0] size);
      case (size)
         2'b00:   byte_en = 4'b0001;
         2'b01:   byte_en = 4'b0011;
         default: byte_en = 4'b1111;
      endcase
   endfunction

   function automatic rv32i_control_word control_rom(input logic [6:0] op,
                                                     input logic [2:0] f3,
                                                     input logic       b30);
      rv32i_control_word cw;
      cw        = '0;
      cw.opcode = op;
      case (op)
         OP_LUI: begin
            cw.load_regfile   = 1'b1;
            cw.regfilemux_sel = RF_IMM;
         end
         OP_AUIPC: begin
            cw.load_regfile = 1'b1;
            cw.alumux1_sel  = 1'b1;
            cw.alumux2_sel  = 1'b1;
         end
         OP_JAL: begin
            cw.load_regfile   = 1'b1;
            cw.regfilemux_sel = RF_PC4;
            cw.alumux1_sel    = 1'b1;
            cw.alumux2_sel    = 1'b1;
         end
         OP_JALR: begin
            cw.load_regfile   = 1'b1;
            cw.regfilemux_sel = RF_PC4;
            cw.alumux2_sel    = 1'b1;
         end
         OP_BR: begin
            cw.cmpop       = f3;
            cw.alumux1_sel = 1'b1;
            cw.alumux2_sel = 1'b1;
         end
         OP_LOAD: begin
            cw.load_regfile   = 1'b1;
            cw.mem_read       = 1'b1;
            cw.regfilemux_sel = RF_MEM;
            cw.alumux2_sel    = 1'b1;
            cw.mem_byte_en    = byte_en(f3[1:0]);
         end
         OP_STORE: begin
            cw.mem_write   = 1'b1;
            cw.alumux2_sel = 1'b1;
            cw.mem_byte_en = byte_en(f3[1:0]);
         end
         OP_IMM: begin
            cw.load_regfile = 1'b1;
            cw.aluop        = f3;
            cw.alumux2_sel  = 1'b1;
            cw.alu_alt      = (f3 == 3'b101) && b30;
            // slti/sltiu compare rs1 against the immediate
            if (f3 == 3'b010) begin
               cw.cmpop      = CMP_BLT;
               cw.cmpmux_sel = 1'b1;
            end else if (f3 == 3'b011) begin
               cw.cmpop      = CMP_BLTU;
               cw.cmpmux_sel = 1'b1;
            end
         end
         OP_REG: begin
            cw.load_regfile = 1'b1;
            cw.aluop        = f3;
            cw.alu_alt      = b30;
            if (f3 == 3'b010)      cw.cmpop = CMP_BLT;
            else if (f3 == 3'b011) cw.cmpop = CMP_BLTU;
         end
         default: cw.cmpop = CMP_BEQ;
      endcase
      return cw;
   endfunction

   logic [XLEN-1:0]   rf [NUM_REGS];
   logic              wb_ok;
   logic [4:0]        rd_idx [2];
   logic [XLEN-1:0]   rd_val [2];
   logic              capture;
   rv32i_control_word cw_next;
   logic [XLEN-1:0]   imm_next;
   logic [XLEN-1:0]   cmp_rhs;

   assign wb_ok     = wb_load_i && (wb_rd_i != 5'd0) && (32'(wb_rd_i) < NUM_REGS);
   assign rd_idx[0] = instr_i[19:15];
   assign rd_idx[1] = instr_i[24:20];

   // The rs2 field is compared even for formats that have no rs2. A false
   // match only costs one bubble.
   assign lu_stall_o = LU_CHECK && in_valid_i && out_valid_o && ctrl_word_o.mem_read &&
                       (rd_o != 5'd0) &&
                       ((rd_o == instr_i[19:15]) || (rd_o == instr_i[24:20]));

   assign in_ready_o = rst && (!out_valid_o || out_ready_i) && !lu_stall_o;
   assign capture    = in_valid_i && in_ready_o;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (wb_ok) begin
         rf[wb_rd_i[AW-1:0]] <= wb_data_i;
      end
   end

   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rd_val[p] = '0;
         if ((rd_idx[p] != 5'd0) && (32'(rd_idx[p]) < NUM_REGS)) begin
            if (BYPASS && wb_ok && (wb_rd_i == rd_idx[p])) rd_val[p] = wb_data_i;
            else                                          rd_val[p] = rf[rd_idx[p][AW-1:0]];
         end
      end
   end

   always_comb begin
      cw_next = control_rom(instr_i[6:0], instr_i[14:12], instr_i[30]);
      if (hd_zero_i) begin
         cw_next.load_regfile = 1'b0;
         cw_next.mem_read     = 1'b0;
         cw_next.mem_write    = 1'b0;
         cw_next.mem_byte_en  = 4'b0000;
      end
   end

   always_comb begin
      imm_next = '0;
      case (instr_i[6:0])
         OP_IMM, OP_LOAD, OP_JALR:
            imm_next = XLEN'($signed(instr_i[31:20]));
         OP_STORE:
            imm_next = XLEN'($signed({instr_i[31:25], instr_i[11:7]}));
         OP_BR:
            imm_next = XLEN'($signed({instr_i[31], instr_i[7], instr_i[30:25],
                                      instr_i[11:8], 1'b0}));
         OP_LUI, OP_AUIPC:
            imm_next = XLEN'($signed({instr_i[31:12], 12'b0}));
         OP_JAL:
            imm_next = XLEN'($signed({instr_i[31], instr_i[19:12], instr_i[20],
                                      instr_i[30:21], 1'b0}));
         default: imm_next = '0;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         out_valid_o <= 1'b0;
         ctrl_word_o <= '0;
         instr_o     <= '0;
         pc_o        <= '0;
         rs1_data_o  <= '0;
         rs2_data_o  <= '0;
         imm_o       <= '0;
         rs1_o       <= '0;
         rs2_o       <= '0;
         rd_o        <= '0;
      end else if (flush_i) begin
         // A handshake taken in this cycle is consumed but dropped here.
         out_valid_o <= 1'b0;
      end else if (capture) begin
         out_valid_o <= 1'b1;
         ctrl_word_o <= cw_next;
         instr_o     <= instr_i;
         pc_o        <= pc_i;
         rs1_data_o  <= rd_val[0];
         rs2_data_o  <= rd_val[1];
         imm_o       <= imm_next;
         rs1_o       <= instr_i[19:15];
         rs2_o       <= instr_i[24:20];
         rd_o        <= instr_i[11:7];
      end else if (out_ready_i) begin
         // Drained with nothing new, or a load-use bubble.
         out_valid_o <= 1'b0;
      end else if (out_valid_o) begin
         // Held by EX: keep the operands in step with regfile writes.
         if (wb_ok && (wb_rd_i == rs1_o)) rs1_data_o <= wb_data_i;
         if (wb_ok && (wb_rd_i == rs2_o)) rs2_data_o <= wb_data_i;
      end
   end

   assign cmp_rhs = ctrl_word_o.cmpmux_sel ? imm_o : rs2_data_o;

   always_comb begin
      case (ctrl_word_o.cmpop)
         3'b000:  br_en_o = (rs1_data_o == cmp_rhs);
         3'b001:  br_en_o = (rs1_data_o != cmp_rhs);
         3'b100:  br_en_o = ($signed(rs1_data_o) <  $signed(cmp_rhs));
         3'b101:  br_en_o = ($signed(rs1_data_o) >= $signed(cmp_rhs));
         3'b110:  br_en_o = (rs1_data_o <  cmp_rhs);
         3'b111:  br_en_o = (rs1_data_o >= cmp_rhs);
         default: br_en_o = 1'b0;
      endcase
   end

endmodule

// File: tb/tb_id_stage_hs.sv
module tb_id_stage_hs;

   localparam int NI = 2;   // [0]: defaults, [1]: NUM_REGS=16, BYPASS=0

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic [31:0] instr = '0;
   logic [31:0] pc = '0;
   logic        wb_load = 1'b0;
   logic [4:0]  wb_rd = '0;
   logic [31:0] wb_data = '0;
   logic        flush = 1'b0;
   logic        hd_zero = 1'b0;
   logic        out_ready = 1'b0;

   logic        in_ready_d  [NI];
   logic        out_valid_d [NI];
   logic        lu_d        [NI];
   logic        br_d        [NI];
   id_stage_hs_pkg::rv32i_control_word cw_d [NI];
   logic [31:0] instr_d [NI];
   logic [31:0] pc_d    [NI];
   logic [31:0] rs1d_d  [NI];
   logic [31:0] rs2d_d  [NI];
   logic [31:0] imm_d   [NI];
   logic [4:0]  rs1_d   [NI];
   logic [4:0]  rs2_d   [NI];
   logic [4:0]  rd_d    [NI];

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   id_stage_hs #(.XLEN(32), .NUM_REGS(32), .BYPASS(1'b1), .LU_CHECK(1'b1)) u_dut (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_d[0]),
      .instr_i(instr), .pc_i(pc), .wb_load_i(wb_load), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .flush_i(flush), .hd_zero_i(hd_zero), .out_valid_o(out_valid_d[0]), .out_ready_i(out_ready),
      .ctrl_word_o(cw_d[0]), .instr_o(instr_d[0]), .pc_o(pc_d[0]), .rs1_data_o(rs1d_d[0]),
      .rs2_data_o(rs2d_d[0]), .imm_o(imm_d[0]), .rs1_o(rs1_d[0]), .rs2_o(rs2_d[0]), .rd_o(rd_d[0]),
      .br_en_o(br_d[0]), .lu_stall_o(lu_d[0]));

   id_stage_hs #(.XLEN(32), .NUM_REGS(16), .BYPASS(1'b0), .LU_CHECK(1'b1)) u_alt (
      .clk(clk), .rst(rst), .in_valid_i(in_valid), .in_ready_o(in_ready_d[1]),
      .instr_i(instr), .pc_i(pc), .wb_load_i(wb_load), .wb_rd_i(wb_rd), .wb_data_i(wb_data),
      .flush_i(flush), .hd_zero_i(hd_zero), .out_valid_o(out_valid_d[1]), .out_ready_i(out_ready),
      .ctrl_word_o(cw_d[1]), .instr_o(instr_d[1]), .pc_o(pc_d[1]), .rs1_data_o(rs1d_d[1]),
      .rs2_data_o(rs2d_d[1]), .imm_o(imm_d[1]), .rs1_o(rs1_d[1]), .rs2_o(rs2_d[1]), .rd_o(rd_d[1]),
      .br_en_o(br_d[1]), .lu_stall_o(lu_d[1]));

   // ---------------- reference model ----------------
   int          nregs  [NI] = '{32, 16};
   bit          bypass [NI] = '{1'b1, 1'b0};
   logic [31:0] rf [NI][32];
   logic        m_valid;
   logic [31:0] m_instr, m_pc, m_imm;
   logic [31:0] m_rs1d [NI];
   logic [31:0] m_rs2d [NI];
   logic        m_mr, m_mw, m_lrf, m_cmux;
   logic [3:0]  m_be;
   logic [2:0]  m_cmp;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] rf_read(input int k, input logic [4:0] idx);
      if (idx == 0 || int'(idx) >= nregs[k]) return 32'h0;
      if (bypass[k] && wb_load && wb_rd == idx) return wb_data;
      return rf[k][idx];
   endfunction

   function automatic logic [31:0] exp_imm(input logic [31:0] w);
      logic [31:0] i_imm, sgn;
      i_imm = $signed(w) >>> 20;
      sgn   = $signed(w) >>> 31;
      case (w[6:0])
         7'b0010011, 7'b0000011, 7'b1100111: return i_imm;
         7'b0100011: return (i_imm & ~32'h1f) | ((w >> 7) & 32'h1f);
         7'b1100011: return (sgn << 12) | (32'(w[7]) << 11) | (32'(w[30:25]) << 5) |
                            (32'(w[11:8]) << 1);
         7'b0110111, 7'b0010111: return w & 32'hffff_f000;
         7'b1101111: return (sgn << 20) | (32'(w[19:12]) << 12) | (32'(w[20]) << 11) |
                            (32'(w[30:21]) << 1);
         default: return 32'h0;
      endcase
   endfunction

   function automatic logic exp_cmp(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      case (op)
         3'b000: return a == b;
         3'b001: return a != b;
         3'b100: return $signed(a) < $signed(b);
         3'b101: return $signed(a) >= $signed(b);
         3'b110: return a < b;
         3'b111: return a >= b;
         default: return 1'b0;
      endcase
   endfunction

   task automatic model_reset();
      m_valid = 0; m_instr = 0; m_pc = 0; m_imm = 0;
      m_mr = 0; m_mw = 0; m_lrf = 0; m_cmux = 0; m_be = 0; m_cmp = 0;
      for (int k = 0; k < NI; k++) begin
         m_rs1d[k] = 0; m_rs2d[k] = 0;
         for (int r = 0; r < 32; r++) rf[k][r] = 0;
      end
   endtask

   task automatic model_capture();
      logic [6:0] op;
      logic [2:0] f3;
      logic is_ld, is_st, wr;
      op = instr[6:0];
      f3 = instr[14:12];
      is_ld = (op == 7'b0000011);
      is_st = (op == 7'b0100011);
      wr = op inside {7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111,
                      7'b0000011, 7'b0010011, 7'b0110011};
      m_instr = instr; m_pc = pc; m_imm = exp_imm(instr);
      for (int k = 0; k < NI; k++) begin
         m_rs1d[k] = rf_read(k, instr[19:15]);
         m_rs2d[k] = rf_read(k, instr[24:20]);
      end
      m_mr  = is_ld && !hd_zero;
      m_mw  = is_st && !hd_zero;
      m_lrf = wr && !hd_zero;
      m_be  = ((is_ld || is_st) && !hd_zero) ?
              (f3[1:0] == 2'b00 ? 4'b0001 : f3[1:0] == 2'b01 ? 4'b0011 : 4'b1111) : 4'b0000;
      m_cmp = 3'b000; m_cmux = 1'b0;
      if (op == 7'b1100011) m_cmp = f3;
      else if ((op == 7'b0010011 || op == 7'b0110011) && (f3 == 3'b010 || f3 == 3'b011)) begin
         m_cmp  = (f3 == 3'b010) ? 3'b100 : 3'b110;
         m_cmux = (op == 7'b0010011);
      end
      m_valid = 1;
   endtask

   // Compare the DUTs against the model, advance the model, then cross one clock edge.
   task automatic tick();
      logic [4:0] hrd;
      logic stall, rdy, cap, wok;
      #1;
      hrd   = m_instr[11:7];
      stall = in_valid && m_valid && m_mr && hrd != 0 &&
              (hrd == instr[19:15] || hrd == instr[24:20]);
      rdy   = (!m_valid || out_ready) && !stall;
      cap   = in_valid && rdy;
      for (int k = 0; k < NI; k++) begin
         chk($sformatf("in_ready[%0d]", k), in_ready_d[k], rdy);
         chk($sformatf("lu_stall[%0d]", k), lu_d[k], stall);
         chk($sformatf("out_valid[%0d]", k), out_valid_d[k], m_valid);
         if (m_valid) begin
            chk($sformatf("instr[%0d]", k), instr_d[k], m_instr);
            chk($sformatf("pc[%0d]", k), pc_d[k], m_pc);
            chk($sformatf("imm[%0d]", k), imm_d[k], m_imm);
            chk($sformatf("rs1[%0d]", k), rs1_d[k], m_instr[19:15]);
            chk($sformatf("rs2[%0d]", k), rs2_d[k], m_instr[24:20]);
            chk($sformatf("rd[%0d]", k), rd_d[k], m_instr[11:7]);
            chk($sformatf("rs1_data[%0d]", k), rs1d_d[k], m_rs1d[k]);
            chk($sformatf("rs2_data[%0d]", k), rs2d_d[k], m_rs2d[k]);
            chk($sformatf("cw.opcode[%0d]", k), cw_d[k].opcode, m_instr[6:0]);
            chk($sformatf("cw.mem_read[%0d]", k), cw_d[k].mem_read, m_mr);
            chk($sformatf("cw.mem_write[%0d]", k), cw_d[k].mem_write, m_mw);
            chk($sformatf("cw.load_regfile[%0d]", k), cw_d[k].load_regfile, m_lrf);
            chk($sformatf("cw.byte_en[%0d]", k), cw_d[k].mem_byte_en, m_be);
            chk($sformatf("cw.cmpop[%0d]", k), cw_d[k].cmpop, m_cmp);
            chk($sformatf("cw.cmpmux[%0d]", k), cw_d[k].cmpmux_sel, m_cmux);
            chk($sformatf("br_en[%0d]", k), br_d[k],
                exp_cmp(m_cmp, m_rs1d[k], m_cmux ? m_imm : m_rs2d[k]));
         end
      end
      if (flush)          m_valid = 0;
      else if (cap)       model_capture();
      else if (out_ready) m_valid = 0;
      else if (m_valid) begin
         for (int k = 0; k < NI; k++) begin
            wok = wb_load && wb_rd != 0 && int'(wb_rd) < nregs[k];
            if (wok && wb_rd == m_instr[19:15]) m_rs1d[k] = wb_data;
            if (wok && wb_rd == m_instr[24:20]) m_rs2d[k] = wb_data;
         end
      end
      for (int k = 0; k < NI; k++)
         if (wb_load && wb_rd != 0 && int'(wb_rd) < nregs[k]) rf[k][wb_rd] = wb_data;
      @(negedge clk);
   endtask

   task automatic idle();
      in_valid = 0; wb_load = 0; flush = 0; hd_zero = 0; out_ready = 1;
   endtask

   function automatic logic [4:0] rnd_reg();
      int r;
      r = $urandom_range(0, 15);
      return (r < 12) ? 5'(r % 8) : 5'($urandom_range(16, 31));
   endfunction

   logic [6:0] ops [10] = '{7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111, 7'b1100011,
                            7'b0000011, 7'b0100011, 7'b0010011, 7'b0110011, 7'b0001111};

   initial begin
      model_reset();
      idle();
      repeat (3) @(negedge clk);
      chk("reset out_valid", out_valid_d[0], 1'b0);
      chk("reset in_ready", in_ready_d[0], 1'b0);
      chk("reset ctrl_word", cw_d[0], 26'h0);
      chk("reset instr", instr_d[0], 32'h0);
      rst = 1;
      #1 chk("ready after release", in_ready_d[0], 1'b1);

      // bypass: x5 old value, then a same-cycle write during capture
      wb_load = 1; wb_rd = 5; wb_data = 32'h1111_1111; tick();
      wb_data = 32'hDEAD_BEEF; in_valid = 1; instr = 32'h0002_8333; pc = 32'h100; tick();
      chk("bypass rs1_data", rs1d_d[0], 32'hDEAD_BEEF);
      chk("no-bypass rs1_data", rs1d_d[1], 32'h1111_1111);

      // load-use: lw x3,0(x1) then add x4,x3,x2
      idle(); in_valid = 1; instr = 32'h0000_A183; pc = 32'h104; tick();
      chk("lw mem_read", cw_d[0].mem_read, 1'b1);
      instr = 32'h0021_8233; pc = 32'h108;
      #1 chk("lu_stall asserted", lu_d[0], 1'b1);
      chk("stall blocks ready", in_ready_d[0], 1'b0);
      tick();
      chk("bubble", out_valid_d[0], 1'b0);
      #1 chk("lu_stall one cycle", lu_d[0], 1'b0);
      tick();
      chk("add after stall", instr_d[0], 32'h0021_8233);

      // backpressure with coherent WB write to x7
      instr = 32'h0070_8433; pc = 32'h10C; tick();
      out_ready = 0; instr = 32'h0002_8333; pc = 32'h110;
      for (int c = 0; c < 3; c++) begin
         wb_load = (c == 1); wb_rd = 7; wb_data = 32'h12;
         #1 chk("hold in_ready", in_ready_d[0], 1'b0);
         tick();
      end
      wb_load = 0;
      chk("coherent rs2_data", rs2d_d[0], 32'h12);
      chk("coherent rs2_data alt", rs2d_d[1], 32'h12);
      chk("held instr", instr_d[0], 32'h0070_8433);
      chk("held pc", pc_d[0], 32'h10C);

      // flush while held, flush with a handshake, then hd_zero on sw x2,4(x1)
      flush = 1; tick();
      chk("flush held", out_valid_d[0], 1'b0);
      out_ready = 1; tick();
      chk("flush drops input", out_valid_d[0], 1'b0);
      flush = 0; hd_zero = 1; instr = 32'h0020_A223; pc = 32'h114; tick();
      chk("hd_zero valid", out_valid_d[0], 1'b1);
      chk("hd_zero mem_write", cw_d[0].mem_write, 1'b0);
      chk("sw imm", imm_d[0], 32'h4);

      // x20 exists only in the 32-register instance
      idle(); wb_load = 1; wb_rd = 20; wb_data = 32'h5; tick();
      wb_load = 0; in_valid = 1; instr = 32'h000A_00B3; pc = 32'h118; tick();
      chk("x20 rs1_data", rs1d_d[0], 32'h5);
      chk("x20 ignored rs1_data", rs1d_d[1], 32'h0);

      // reset mid-stream
      idle(); out_ready = 0;
      #2 rst = 0;
      #1 chk("mid reset out_valid", out_valid_d[0], 1'b0);
      chk("mid reset rs1_data", rs1d_d[0], 32'h0);
      chk("mid reset in_ready", in_ready_d[0], 1'b0);
      model_reset();
      @(negedge clk); rst = 1;
      #1 chk("ready after mid reset", in_ready_d[0], 1'b1);

      for (int n = 0; n < 3000; n++) begin
         in_valid  = ($urandom_range(0, 9) < 7);
         out_ready = ($urandom_range(0, 9) < 7);
         flush     = ($urandom_range(0, 19) == 0);
         hd_zero   = ($urandom_range(0, 9) == 0);
         wb_load   = $urandom_range(0, 1);
         wb_rd     = rnd_reg();
         wb_data   = $urandom;
         pc        = $urandom;
         instr     = $urandom;
         instr[6:0]   = ops[$urandom_range(0, 9)];
         instr[11:7]  = rnd_reg();
         instr[19:15] = rnd_reg();
         instr[24:20] = rnd_reg();
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
